// File: rtl/fetch_unit_if.sv
// Bundle of the PC, instruction-memory and decode-side signals of the fetch stage.
// master: the fetch unit. slave: the PC / memory / decode environment.
interface fetch_unit_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
);
  logic [ADDR_W-1:0]  pc_addr;
  logic               pc_w_en;
  logic               flush;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_gnt;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;
  logic               out_misaligned;

  modport master (
    input  pc_addr, flush, imem_gnt, imem_rvalid, imem_rdata, out_ready,
    output pc_w_en, imem_req, imem_addr, out_valid, out_instr, out_pc, out_misaligned
  );

  modport slave (
    output pc_addr, flush, imem_gnt, imem_rvalid, imem_rdata, out_ready,
    input  pc_w_en, imem_req, imem_addr, out_valid, out_instr, out_pc, out_misaligned
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: single-outstanding memory read, one-entry output
// buffer toward decode, PC advance on grant, flush on redirect.
//
// Handshakes:
//   memory : a request transfers on a cycle where imem_req && imem_gnt; the
//            response is the next cycle with imem_rvalid (only one in flight).
//   decode : an instruction transfers on a cycle where out_valid && out_ready;
//            out_* stay stable while out_valid is high and out_ready is low.
module fetch_unit #(
  parameter int ADDR_W      = 32,
  parameter int INSTR_W     = 32,
  parameter int ALIGN_CHECK = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus,
  output logic [1:0]   dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e             state_q;
  logic               discard_q;
  logic [ADDR_W-1:0]  req_pc_q;
  logic [ADDR_W-1:0]  out_pc_q;
  logic [INSTR_W-1:0] out_instr_q;
  logic               out_mis_q;
  logic               misaligned;
  logic               req;

  // A PC not on a word boundary is reported instead of fetched.
  assign misaligned = (ALIGN_CHECK != 0) && (bus.pc_addr[1:0] != 2'b00);

  // Request only from IDLE; flush wins, and nothing is requested during reset.
  assign req = rst_n && (state_q == IDLE) && !bus.flush && !misaligned;

  assign bus.imem_req       = req;
  assign bus.imem_addr      = bus.pc_addr;
  assign bus.pc_w_en        = req && bus.imem_gnt;
  assign bus.out_valid      = (state_q == HOLD);
  assign bus.out_instr      = out_instr_q;
  assign bus.out_pc         = out_pc_q;
  assign bus.out_misaligned = out_mis_q;
  assign dbg_state_o        = state_q;

  // Fetch FSM plus the output buffer and the in-flight PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      discard_q   <= 1'b0;
      req_pc_q    <= '0;
      out_pc_q    <= '0;
      out_instr_q <= '0;
      out_mis_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!bus.flush) begin
            if (misaligned) begin
              out_pc_q    <= bus.pc_addr;
              out_instr_q <= '0;
              out_mis_q   <= 1'b1;
              state_q     <= HOLD;
            end else if (bus.imem_gnt) begin
              req_pc_q <= bus.pc_addr;
              state_q  <= WAIT;
            end
          end
        end
        WAIT: begin
          if (bus.imem_rvalid) begin
            if (discard_q || bus.flush) begin
              // Response belongs to a redirected-away path: drop it.
              discard_q <= 1'b0;
              state_q   <= IDLE;
            end else begin
              out_instr_q <= bus.imem_rdata;
              out_pc_q    <= req_pc_q;
              out_mis_q   <= 1'b0;
              state_q     <= HOLD;
            end
          end else if (bus.flush) begin
            // Still must consume the outstanding response before refetching.
            discard_q <= 1'b1;
          end
        end
        HOLD: begin
          if (bus.flush || bus.out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a scoreboard on the decode interface.
module tb_fetch_unit;

  localparam int AW = 32;
  localparam int IW = 32;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  int n_cmp;
  int n_err;
  int n_wen;
  logic [64:0] exp_q[$];

  fetch_unit_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

  fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .ALIGN_CHECK(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Grant a fetch at addr, return data one cycle later, end in HOLD with out_ready low.
  task automatic fetch_to_hold(input logic [31:0] addr, input logic [31:0] data, input bit push);
    bus.out_ready = 1'b0;
    bus.pc_addr   = addr;
    bus.imem_gnt  = 1'b1;
    #1;
    chk("idle_req", 65'(bus.imem_req), 65'd1);
    chk("idle_wen", 65'(bus.pc_w_en), 65'd1);
    chk("idle_addr", 65'(bus.imem_addr), 65'(addr));
    if (push) exp_q.push_back({1'b0, addr, data});
    step();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = data;
    #1;
    chk("wait_req", 65'(bus.imem_req), 65'd0);
    chk("wait_state", 65'(dbg_state), 65'(S_WAIT));
    step();
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    #1;
    chk("hold_valid", 65'(bus.out_valid), 65'd1);
    chk("hold_pc", 65'(bus.out_pc), 65'(addr));
    chk("hold_instr", 65'(bus.out_instr), 65'(data));
  endtask

  // Monitor: pops the expected queue on every accepted instruction.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.pc_w_en) n_wen++;
      if (bus.out_valid && bus.out_ready && !bus.flush) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_output: got mis=%0b pc=%0h instr=%0h, required no output",
                   bus.out_misaligned, bus.out_pc, bus.out_instr);
        end else begin
          logic [64:0] e;
          logic [64:0] a;
          e = exp_q.pop_front();
          a = {bus.out_misaligned, bus.out_pc, bus.out_instr};
          if (a !== e) begin
            n_err++;
            $display("FAIL handshake: got %0h, required %0h", a, e);
          end
        end
      end
    end
  end

  logic [31:0] seq_pc[3];
  logic [31:0] seq_data[3];
  int w0;

  initial begin
    n_cmp = 0;
    n_err = 0;
    n_wen = 0;
    seq_pc   = '{32'h0, 32'h4, 32'h8};
    seq_data = '{32'h00500093, 32'h00A00113, 32'h002081B3};

    // Reset
    rst_n           = 1'b0;
    bus.pc_addr     = '0;
    bus.flush       = 1'b0;
    bus.imem_gnt    = 1'b1;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.out_ready   = 1'b0;
    #2;
    chk("rst_req", 65'(bus.imem_req), 65'd0);
    chk("rst_wen", 65'(bus.pc_w_en), 65'd0);
    chk("rst_valid", 65'(bus.out_valid), 65'd0);
    chk("rst_out", {bus.out_misaligned, bus.out_pc, bus.out_instr}, 65'd0);
    chk("rst_state", 65'(dbg_state), 65'(S_IDLE));
    bus.imem_gnt = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();

    // Sequential fetch
    w0 = n_wen;
    for (int i = 0; i < 3; i++) begin
      fetch_to_hold(seq_pc[i], seq_data[i], 1'b1);
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      chk("seq_back_idle", 65'(dbg_state), 65'(S_IDLE));
    end
    chk("seq_wen_pulses", 65'(n_wen - w0), 65'd3);

    // Backpressure: five held cycles with a tempting grant
    fetch_to_hold(32'h20, 32'h00308233, 1'b1);
    bus.imem_gnt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", 65'(bus.out_valid), 65'd1);
      chk("bp_pc", 65'(bus.out_pc), 65'h20);
      chk("bp_instr", 65'(bus.out_instr), 65'h00308233);
      chk("bp_req", 65'(bus.imem_req), 65'd0);
      chk("bp_wen", 65'(bus.pc_w_en), 65'd0);
    end
    bus.imem_gnt  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("bp_idle", 65'(dbg_state), 65'(S_IDLE));

    // Flush in WAIT, response arrives later and is dropped
    bus.pc_addr  = 32'h10;
    bus.imem_gnt = 1'b1;
    #1;
    chk("fw_wen", 65'(bus.pc_w_en), 65'd1);
    step();
    bus.imem_gnt = 1'b0;
    bus.flush    = 1'b1;
    #1;
    chk("fw_req", 65'(bus.imem_req), 65'd0);
    step();
    bus.flush   = 1'b0;
    bus.pc_addr = 32'h200;
    #1;
    chk("fw_still_wait", 65'(dbg_state), 65'(S_WAIT));
    chk("fw_no_req", 65'(bus.imem_req), 65'd0);
    step();
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hDEADBEEF;
    step();
    bus.imem_rvalid = 1'b0;
    #1;
    chk("fw_idle", 65'(dbg_state), 65'(S_IDLE));
    chk("fw_valid", 65'(bus.out_valid), 65'd0);
    chk("fw_new_req", 65'(bus.imem_req), 65'd1);
    chk("fw_new_addr", 65'(bus.imem_addr), 65'h200);
    fetch_to_hold(32'h200, 32'h00000013, 1'b1);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;

    // Flush coincident with rvalid
    bus.pc_addr  = 32'h30;
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h12345678;
    bus.flush       = 1'b1;
    step();
    bus.imem_rvalid = 1'b0;
    bus.flush       = 1'b0;
    #1;
    chk("fr_idle", 65'(dbg_state), 65'(S_IDLE));
    chk("fr_valid", 65'(bus.out_valid), 65'd0);

    // Flush in IDLE blocks the request
    bus.pc_addr  = 32'h40;
    bus.flush    = 1'b1;
    bus.imem_gnt = 1'b1;
    #1;
    chk("fi_req", 65'(bus.imem_req), 65'd0);
    chk("fi_wen", 65'(bus.pc_w_en), 65'd0);
    step();
    bus.flush    = 1'b0;
    bus.imem_gnt = 1'b0;
    chk("fi_idle", 65'(dbg_state), 65'(S_IDLE));

    // Flush in HOLD overrides the handshake
    fetch_to_hold(32'h44, 32'hAAAA5555, 1'b0);
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    chk("fh_valid", 65'(bus.out_valid), 65'd0);
    chk("fh_idle", 65'(dbg_state), 65'(S_IDLE));

    // Misaligned PC
    bus.pc_addr  = 32'h6;
    bus.imem_gnt = 1'b1;
    #1;
    chk("mis_req", 65'(bus.imem_req), 65'd0);
    chk("mis_wen", 65'(bus.pc_w_en), 65'd0);
    exp_q.push_back({1'b1, 32'h6, 32'h0});
    step();
    bus.imem_gnt = 1'b0;
    chk("mis_valid", 65'(bus.out_valid), 65'd1);
    chk("mis_flag", 65'(bus.out_misaligned), 65'd1);
    chk("mis_pc", 65'(bus.out_pc), 65'h6);
    chk("mis_instr", 65'(bus.out_instr), 65'd0);
    chk("mis_hold_wen", 65'(bus.pc_w_en), 65'd0);
    bus.out_ready = 1'b1;
    bus.pc_addr   = 32'h8;
    step();
    bus.out_ready = 1'b0;
    chk("mis_idle", 65'(dbg_state), 65'(S_IDLE));

    // Asynchronous reset while in HOLD
    fetch_to_hold(32'h50, 32'h0BADF00D, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 65'(bus.out_valid), 65'd0);
    chk("ar_state", 65'(dbg_state), 65'(S_IDLE));
    chk("ar_req", 65'(bus.imem_req), 65'd0);
    chk("ar_out", {bus.out_misaligned, bus.out_pc, bus.out_instr}, 65'd0);
    step();
    step();
    rst_n = 1'b1;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hCAFEF00D;
    step();
    bus.imem_rvalid = 1'b0;
    #1;
    chk("ar_stray_valid", 65'(bus.out_valid), 65'd0);
    chk("ar_stray_state", 65'(dbg_state), 65'(S_IDLE));
    step();
    chk("ar_stray_valid2", 65'(bus.out_valid), 65'd0);

    // Every pushed expectation must have been consumed
    chk("exp_q_empty", 65'(exp_q.size()), 65'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
